// File: rtl/qr_pkg.sv
// Shared definitions for the QR engine divider scheduler: FSM states,
// response error codes and the saturation fill used for failed divisions.
package qr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ZERO = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int DW_DEF = 16;

  localparam logic [1:0] ERR_OK = 2'b00;
  localparam logic [1:0] ERR_DZ = 2'b01;
  localparam logic [1:0] ERR_TO = 2'b10;

  // Replicated across the quotient width to build the all-ones error value.
  localparam logic SAT_BIT = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: picks the first request at or after ptr,
// wrapping, and reports it both one-hot and as a binary index.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] id,
  output logic          any
);

  // Scan from the farthest position back toward ptr so the nearest wins.
  always_comb begin
    gnt = '0;
    id  = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        id     = IW'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qr_div_sched.sv
// Round-robin scheduler sharing one iterative divider between N_REQ
// requesters, with local divide-by-zero handling and a hung-divider watchdog.
module qr_div_sched
  import qr_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_REQ-1:0]      i_req,
  input  logic [N_REQ*DW-1:0]   i_a,
  input  logic [N_REQ*DW-1:0]   i_b,
  output logic [N_REQ-1:0]      o_gnt,
  output logic [N_REQ-1:0]      o_rsp_vld,
  output logic [DW-1:0]         o_rsp_data,
  output logic [1:0]            o_rsp_err,
  output logic [DW-1:0]         o_div_a,
  output logic [DW-1:0]         o_div_b,
  output logic                  o_div_en,
  input  logic                  i_div_fin,
  input  logic [DW-1:0]         i_div_result,
  output logic                  o_busy
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [DW-1:0] SAT = {DW{SAT_BIT}};
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     id_q;
  logic [7:0]        wd_cnt;
  logic [DW-1:0]     a_q;
  logic [DW-1:0]     b_q;

  logic [N_REQ-1:0]  arb_gnt;
  logic [IW-1:0]     arb_id;
  logic              arb_any;
  logic [DW-1:0]     sel_a;
  logic [DW-1:0]     sel_b;
  logic [IW-1:0]     next_ptr;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (i_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .id  (arb_id),
    .any (arb_any)
  );

  always_comb begin
    sel_a    = i_a[arb_id*DW +: DW];
    sel_b    = i_b[arb_id*DW +: DW];
    next_ptr = (arb_id == IW'(N_REQ - 1)) ? '0 : arb_id + 1'b1;
  end

  // Grant is gated by reset so every output reads zero while reset is held.
  assign o_gnt   = (state == IDLE && i_rst_n) ? arb_gnt : '0;
  assign o_div_a = a_q;
  assign o_div_b = b_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      wd_cnt     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      o_rsp_vld  <= '0;
      o_rsp_data <= '0;
      o_rsp_err  <= ERR_OK;
      o_div_en   <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            id_q   <= arb_id;
            a_q    <= sel_a;
            b_q    <= sel_b;
            rr_ptr <= next_ptr;
            o_busy <= 1'b1;
            if (sel_b == '0) begin
              state <= ZERO;
            end else begin
              state    <= WAIT;
              wd_cnt   <= '0;
              o_div_en <= 1'b1;
            end
          end
        end
        // A fin arriving in the expiry cycle still wins over the watchdog.
        WAIT: begin
          if (i_div_fin) begin
            o_rsp_data <= i_div_result;
            o_rsp_err  <= ERR_OK;
            o_rsp_vld  <= {{(N_REQ-1){1'b0}}, 1'b1} << id_q;
            o_div_en   <= 1'b0;
            state      <= RESP;
          end else if (wd_cnt == WD_LAST) begin
            o_rsp_data <= SAT;
            o_rsp_err  <= ERR_TO;
            o_rsp_vld  <= {{(N_REQ-1){1'b0}}, 1'b1} << id_q;
            o_div_en   <= 1'b0;
            state      <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        ZERO: begin
          o_rsp_data <= SAT;
          o_rsp_err  <= ERR_DZ;
          o_rsp_vld  <= {{(N_REQ-1){1'b0}}, 1'b1} << id_q;
          state      <= RESP;
        end
        RESP: begin
          o_rsp_vld <= '0;
          o_busy    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qr_div_sched.sv
// Directed bench for qr_div_sched with a latency-programmable divider model.
module tb_qr_div_sched;

  logic        i_clk;
  logic        i_rst_n;
  logic [3:0]  i_req;
  logic [63:0] i_a;
  logic [63:0] i_b;
  logic [3:0]  o_gnt;
  logic [3:0]  o_rsp_vld;
  logic [15:0] o_rsp_data;
  logic [1:0]  o_rsp_err;
  logic [15:0] o_div_a;
  logic [15:0] o_div_b;
  logic        o_div_en;
  logic        i_div_fin;
  logic [15:0] i_div_result;
  logic        o_busy;

  int          total;
  int          bad;
  int          rsp_cnt [4];
  int          div_lat;
  bit          div_hang;
  bit          force_fin;
  int          en_cnt;

  qr_div_sched #(.N_REQ(4), .DW(16), .TIMEOUT(32)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req        (i_req),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_gnt        (o_gnt),
    .o_rsp_vld    (o_rsp_vld),
    .o_rsp_data   (o_rsp_data),
    .o_rsp_err    (o_rsp_err),
    .o_div_a      (o_div_a),
    .o_div_b      (o_div_b),
    .o_div_en     (o_div_en),
    .i_div_fin    (i_div_fin),
    .i_div_result (i_div_result),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Divider model: fin after div_lat cycles of enable, or never when hung.
  always @(posedge i_clk) en_cnt <= o_div_en ? en_cnt + 1 : 0;
  assign i_div_fin = force_fin | (o_div_en && !div_hang && en_cnt == div_lat);

  task automatic tick();
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 4; k++) rsp_cnt[k] += int'(o_rsp_vld[k]);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_cnt();
    for (int k = 0; k < 4; k++) rsp_cnt[k] = 0;
  endtask

  initial begin
    int w;
    total = 0; bad = 0;
    i_clk = 0; i_rst_n = 1; i_req = '0; i_a = '0; i_b = '0;
    div_lat = 0; div_hang = 0; force_fin = 0; i_div_result = 16'h0;
    clr_cnt();

    // Reset state.
    #2 i_rst_n = 0;
    tick(); tick();
    chk("rst_gnt", 32'(o_gnt), 32'h0);
    chk("rst_rsp_vld", 32'(o_rsp_vld), 32'h0);
    chk("rst_div_en", 32'(o_div_en), 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_rsp_data", 32'(o_rsp_data), 32'h0);
    chk("rst_div_a", 32'(o_div_a), 32'h0);

    // All four requesting continuously from reset, divider latency 0.
    i_req = 4'b1111;
    i_a = {16'h0040, 16'h0030, 16'h0020, 16'h0010};
    i_b = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
    i_div_result = 16'h0005;
    #1 i_rst_n = 1;
    #1;
    clr_cnt();
    for (int g = 0; g < 5; g++) begin
      w = 0;
      while (o_gnt == 4'b0 && w < 10) begin
        tick();
        w++;
      end
      chk($sformatf("rr_gnt%0d", g), 32'(o_gnt), 32'h1 << (g % 4));
      tick();
    end
    for (int k = 0; k < 4; k++) chk($sformatf("rr_rsp_cnt%0d", k), 32'(rsp_cnt[k]), 32'd1);
    i_req = '0;
    repeat (5) tick();
    chk("rr_idle", 32'(o_busy), 32'h0);

    // Single request on 2, latency 4.
    div_lat = 4;
    i_div_result = 16'h0002;
    i_a[32 +: 16] = 16'h4000;
    i_b[32 +: 16] = 16'h2000;
    i_req = 4'b0100;
    #1;
    chk("s_gnt", 32'(o_gnt), 32'h4);
    tick();
    i_req = '0;
    chk("s_en_t1", 32'(o_div_en), 32'h1);
    chk("s_div_a", 32'(o_div_a), 32'h4000);
    chk("s_div_b", 32'(o_div_b), 32'h2000);
    chk("s_busy", 32'(o_busy), 32'h1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      chk($sformatf("s_en_t%0d", c), 32'(o_div_en), 32'h1);
      chk($sformatf("s_novld_t%0d", c), 32'(o_rsp_vld), 32'h0);
    end
    tick();
    chk("s_en_t6", 32'(o_div_en), 32'h0);
    chk("s_vld", 32'(o_rsp_vld), 32'h4);
    chk("s_data", 32'(o_rsp_data), 32'h0002);
    chk("s_err", 32'(o_rsp_err), 32'h0);
    tick();
    chk("s_vld_drop", 32'(o_rsp_vld), 32'h0);
    chk("s_data_hold", 32'(o_rsp_data), 32'h0002);
    chk("s_busy_drop", 32'(o_busy), 32'h0);

    // Divide by zero on requester 1, with a stray fin during ZERO.
    i_a[16 +: 16] = 16'h1234;
    i_b[16 +: 16] = 16'h0000;
    i_req = 4'b0010;
    #1;
    chk("z_gnt", 32'(o_gnt), 32'h2);
    tick();
    i_req = '0;
    force_fin = 1;
    chk("z_en_t1", 32'(o_div_en), 32'h0);
    chk("z_novld_t1", 32'(o_rsp_vld), 32'h0);
    tick();
    force_fin = 0;
    chk("z_vld", 32'(o_rsp_vld), 32'h2);
    chk("z_data", 32'(o_rsp_data), 32'hFFFF);
    chk("z_err", 32'(o_rsp_err), 32'h1);
    chk("z_en_t2", 32'(o_div_en), 32'h0);
    tick();
    chk("z_busy_drop", 32'(o_busy), 32'h0);

    // Stray fin while idle.
    clr_cnt();
    force_fin = 1;
    tick(); tick();
    force_fin = 0;
    tick();
    chk("i_busy", 32'(o_busy), 32'h0);
    chk("i_rsp_cnt", 32'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3]), 32'h0);
    chk("i_err_hold", 32'(o_rsp_err), 32'h1);

    // Timeout on requester 3 with a hung divider.
    div_hang = 1;
    i_a[48 +: 16] = 16'h7000;
    i_b[48 +: 16] = 16'h0007;
    i_req = 4'b1000;
    #1;
    chk("t_gnt", 32'(o_gnt), 32'h8);
    tick();
    i_req = '0;
    repeat (31) tick();
    chk("t_en_t32", 32'(o_div_en), 32'h1);
    chk("t_novld_t32", 32'(o_rsp_vld), 32'h0);
    tick();
    chk("t_vld", 32'(o_rsp_vld), 32'h8);
    chk("t_err", 32'(o_rsp_err), 32'h2);
    chk("t_data", 32'(o_rsp_data), 32'hFFFF);
    tick();

    // Fin injected in the expiry cycle counts as success.
    i_div_result = 16'h1234;
    i_a[0 +: 16] = 16'h0300;
    i_b[0 +: 16] = 16'h0003;
    i_req = 4'b0001;
    #1;
    chk("tf_gnt", 32'(o_gnt), 32'h1);
    tick();
    i_req = '0;
    repeat (31) tick();
    force_fin = 1;
    tick();
    force_fin = 0;
    chk("tf_vld", 32'(o_rsp_vld), 32'h1);
    chk("tf_err", 32'(o_rsp_err), 32'h0);
    chk("tf_data", 32'(o_rsp_data), 32'h1234);
    tick();

    // Reset during WAIT; held request is regranted from pointer 0.
    i_req = 4'b1100;
    #1;
    chk("r_gnt_pre", 32'(o_gnt), 32'h4);
    tick();
    tick(); tick();
    chk("r_en_pre", 32'(o_div_en), 32'h1);
    i_rst_n = 0;
    #1;
    chk("r_en", 32'(o_div_en), 32'h0);
    chk("r_busy", 32'(o_busy), 32'h0);
    chk("r_gnt", 32'(o_gnt), 32'h0);
    chk("r_data", 32'(o_rsp_data), 32'h0);
    chk("r_div_a", 32'(o_div_a), 32'h0);
    tick();
    clr_cnt();
    i_rst_n = 1;
    #1;
    chk("r_regnt", 32'(o_gnt), 32'h4);
    repeat (5) tick();
    chk("r_no_rsp", 32'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3]), 32'h0);
    i_req = '0;
    div_hang = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
